button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Input-side front end for the calculator datapath and its display mux.
- Takes the nine raw, bouncing push-buttons and conditions them for the clocked design: synchronise, debounce, edge-detect.
- Outputs one-clock press pulses plus an encoded, single-key-lockout key event, so the arithmetic logic never uses buttons as clocks.

Parameters:
- N_BTN, 9: number of buttons; index i maps to button B(i+1).
- DEBOUNCE_CYCLES, 500000: consecutive stable clk_in cycles required before a level change is accepted; legal range is 2 or more.

Ports:
- clk_in, input, 1: single system clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-low reset.
- btn_raw, input, N_BTN: raw asynchronous button levels, 1 = pressed.
- btn_level, output, N_BTN: debounced button levels.
- press_pulse, output, N_BTN: one-cycle pulse per debounced rising edge; not filtered by lockout.
- key_valid, output, 1: one-cycle strobe for an accepted key event.
- key_code, output, 4: accepted key number, i+1 (1..9); holds its value until the next key_valid.
- busy, output, 1: 1 while the FSM is in LOCKED.

Behaviour:
- Reset:
  - Applies when reset is sampled 0 at a clk_in edge.
  - Clears: sync flops, debounce counters, btn_level, press_pulse, key_valid, key_code (all 0); FSM goes to IDLE, busy=0.
  - Reset mid-debounce or mid-hold discards all progress.
  - After reset release, a button still held must pass a full debounce before it is reported.
- Synchroniser: two-flop synchroniser per bit, giving sync[i].
- Debounce, per button, with counter width $clog2(DEBOUNCE_CYCLES):
  - If sync[i] == btn_level[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_level[i] <= sync[i] and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return to a matching value restarts the count, so glitches shorter than DEBOUNCE_CYCLES sync cycles are ignored.
  - Press and release are debounced identically.
- Latency: let D = DEBOUNCE_CYCLES, and let btn_raw change before edge 0 and then stay stable.
  - btn_level changes after edge D+1.
  - press_pulse / key_valid are high for exactly the cycle after edge D+2.
- press_pulse[i]: registered; 1 for one cycle when btn_level[i] is 1 and its previous value was 0. Releases produce no pulse.
- Lockout FSM:
  - IDLE:
    - If any rise bit is set, select the lowest index i among the rise bits.
    - Register key_valid=1 and key_code=i+1, then go to LOCKED.
    - Multiple simultaneous rises produce exactly one event, for the lowest index.
  - LOCKED:
    - busy=1; no key_valid is generated, even if other buttons rise.
    - Return to IDLE on the edge where btn_level == 0 (all buttons released).
    - A press accepted after that edge is a new event.
- key_valid is never high on two consecutive cycles.
- key_code is never 0 after the first event.
- btn_raw values on bits beyond N_BTN do not exist; no X propagation is permitted from reset.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
1. Reset held low for 3 cycles with btn_raw=9'h1FF → all outputs 0. After release, btn_level becomes 9'h1FF after edge 5; key_valid pulses once with key_code=1; press_pulse=9'h1FF for one cycle.
2. From idle, btn_raw[4] set before edge 0 → btn_level[4]=1 after edge 5; key_valid=1 with key_code=5 only in the cycle after edge 6; busy=1 from then on.
3. Glitches: btn_raw[0] high for 3 cycles then low; repeat 10 times → btn_level, press_pulse and key_valid stay 0 throughout.
4. While key 5 is held, press btn_raw[2] → press_pulse[2] pulses, no key_valid, key_code stays 5. Release both → busy drops after the last release debounces. Then press btn_raw[8] → key_valid with key_code=9.
5. Simultaneous press of btn_raw[6] and btn_raw[3] → a single key_valid with key_code=4, and press_pulse=9'h048.
6. Hold btn_raw[1] and pulse reset low for 1 cycle mid-debounce (at count 2) → counter cleared. btn_level[1] rises only 5 edges after reset returns high; exactly one key_valid with key_code=2.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects the raw
// push-buttons, then emits one-clock press pulses plus a single-key-lockout
// encoded key event for the calculator datapath.
module button_conditioner #(
    parameter int unsigned N_BTN           = 9,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic             key_valid,
    output logic [3:0]       key_code,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] level_prev_q;
    logic [N_BTN-1:0] pulse_q;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] rise_c;
    logic [3:0]       sel_code_c;
    state_e           state_q;
    logic             key_valid_q;
    logic [3:0]       key_code_q;
    logic             busy_q;

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-button debounce: a level change is accepted only after the
    // synchronised value has disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < int'(N_BTN); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state and edge-detect registers.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            level_q      <= '0;
            level_prev_q <= '0;
            pulse_q      <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q      <= level_d;
            level_prev_q <= level_q;
            pulse_q      <= rise_c;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Debounced rising edges and lowest-index priority encode of them.
    always_comb begin
        rise_c     = level_q & ~level_prev_q;
        sel_code_c = '0;
        for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
            if (rise_c[i]) begin
                sel_code_c = 4'(i + 1);
            end
        end
    end

    // Lockout FSM: one key event per press, re-armed once all buttons release.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q     <= IDLE;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|rise_c) begin
                        key_valid_q <= 1'b1;
                        key_code_q  <= sel_code_c;
                        busy_q      <= 1'b1;
                        state_q     <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (level_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign press_pulse = pulse_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a short debounce window.
module tb_button_conditioner;

    localparam int N  = 9;
    localparam int DB = 4;

    logic         clk_in = 1'b0;
    logic         reset  = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] press_pulse;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: sync pipeline, sample history per button,
    // debounced level, and lockout flag.
    logic [N-1:0]  m_s1, m_s2, m_lvl, m_prev, m_pulse;
    logic [DB-1:0] m_hist [N];
    logic          m_kv, m_locked;
    logic [3:0]    m_kc;

    button_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(DB)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .press_pulse (press_pulse),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural model: a level flips once the last DB synchronised samples
    // all disagree with it; events come from rising levels while unlocked.
    task automatic model_step();
        logic [N-1:0] rise;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0; m_pulse = '0;
            m_kv = 1'b0; m_kc = '0; m_locked = 1'b0;
            for (int i = 0; i < N; i++) m_hist[i] = '0;
        end else begin
            rise    = m_lvl & ~m_prev;
            m_pulse = rise;
            m_kv    = 1'b0;
            if (!m_locked) begin
                if (rise != '0) begin
                    m_kv = 1'b1;
                    for (int i = N - 1; i >= 0; i--) if (rise[i]) m_kc = 4'(i + 1);
                    m_locked = 1'b1;
                end
            end else if (m_lvl == '0) begin
                m_locked = 1'b0;
            end
            m_prev = m_lvl;
            for (int i = 0; i < N; i++) begin
                m_hist[i] = {m_hist[i][DB-2:0], m_s2[i]};
                if (m_hist[i] == {DB{~m_lvl[i]}}) m_lvl[i] = ~m_lvl[i];
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
    endtask

    task automatic settle();
        btn_raw = '0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; btn_raw = 9'h1FF;
        repeat (3) tick();
        n_cmp++;
        if ({btn_level, press_pulse, key_valid, key_code, busy} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_zero: got %h want 0", {btn_level, press_pulse, key_valid, key_code, busy});
        end
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if ({btn_level, press_pulse, key_valid, key_code, busy} !== {m_lvl, m_pulse, m_kv, m_kc, m_locked}) begin
                n_err++;
                $display("FAIL reset_model c%0d: got %h want %h", c,
                         {btn_level, press_pulse, key_valid, key_code, busy}, {m_lvl, m_pulse, m_kv, m_kc, m_locked});
            end
            n_cmp++;
            if (btn_level !== ((c >= 5) ? 9'h1FF : 9'h000)) begin
                n_err++; $display("FAIL reset_level c%0d: got %h", c, btn_level);
            end
            n_cmp++;
            if ({key_valid, press_pulse} !== ((c == 6) ? {1'b1, 9'h1FF} : 10'h0)) begin
                n_err++; $display("FAIL reset_event c%0d: kv=%b pulse=%h", c, key_valid, press_pulse);
            end
            if (c == 6) begin
                n_cmp++;
                if (key_code !== 4'd1) begin
                    n_err++; $display("FAIL reset_code: got %0d want 1", key_code);
                end
            end
        end
        settle();
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 6; c++) begin
                btn_raw = (c < 3) ? 9'h001 : 9'h000;
                tick();
                n_cmp++;
                if ({btn_level, press_pulse, key_valid} !== 19'h0 ||
                    {btn_level, press_pulse, key_valid, key_code, busy} !== {m_lvl, m_pulse, m_kv, m_kc, m_locked}) begin
                    n_err++;
                    $display("FAIL glitch r%0d c%0d: lvl=%h pulse=%h kv=%b", r, c, btn_level, press_pulse, key_valid);
                end
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_single();
        btn_raw = 9'h010;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if ({btn_level, press_pulse, key_valid, key_code, busy} !== {m_lvl, m_pulse, m_kv, m_kc, m_locked}) begin
                n_err++;
                $display("FAIL single_model c%0d: got %h want %h", c,
                         {btn_level, press_pulse, key_valid, key_code, busy}, {m_lvl, m_pulse, m_kv, m_kc, m_locked});
            end
            n_cmp++;
            if (btn_level[4] !== (c >= 5) || key_valid !== (c == 6) || busy !== (c >= 6) ||
                (c >= 6 && key_code !== 4'd5)) begin
                n_err++;
                $display("FAIL single_timing c%0d: lvl=%h kv=%b busy=%b code=%0d", c, btn_level, key_valid, busy, key_code);
            end
        end
    endtask

    task automatic test_hold_other();
        int pulses = 0, kvs = 0, drop = -1;
        btn_raw = 9'h014;
        for (int c = 0; c < 10; c++) begin
            tick();
            pulses += int'(press_pulse[2]);
            kvs += int'(key_valid);
            n_cmp++;
            if ({btn_level, press_pulse, key_valid, key_code, busy} !== {m_lvl, m_pulse, m_kv, m_kc, m_locked}) begin
                n_err++;
                $display("FAIL hold_model c%0d: got %h want %h", c,
                         {btn_level, press_pulse, key_valid, key_code, busy}, {m_lvl, m_pulse, m_kv, m_kc, m_locked});
            end
        end
        n_cmp++;
        if (pulses != 1 || kvs != 0 || key_code !== 4'd5) begin
            n_err++; $display("FAIL hold_lockout: pulses=%0d kvs=%0d code=%0d want 1/0/5", pulses, kvs, key_code);
        end
        btn_raw = '0;
        for (int c = 0; c < 20 && drop < 0; c++) begin
            tick();
            if (!busy) drop = c;
        end
        n_cmp++;
        if (drop != 6) begin
            n_err++; $display("FAIL hold_release: busy dropped after edge %0d want 6", drop);
        end
        btn_raw = 9'h100;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (key_valid !== (c == 6) || (c == 6 && key_code !== 4'd9)) begin
                n_err++; $display("FAIL hold_next c%0d: kv=%b code=%0d want code 9", c, key_valid, key_code);
            end
        end
        settle();
    endtask

    task automatic test_simultaneous();
        int kvs = 0;
        btn_raw = 9'h048;
        for (int c = 0; c < 10; c++) begin
            tick();
            kvs += int'(key_valid);
            n_cmp++;
            if ({btn_level, press_pulse, key_valid, key_code, busy} !== {m_lvl, m_pulse, m_kv, m_kc, m_locked}) begin
                n_err++;
                $display("FAIL simul_model c%0d: got %h want %h", c,
                         {btn_level, press_pulse, key_valid, key_code, busy}, {m_lvl, m_pulse, m_kv, m_kc, m_locked});
            end
            if (c == 6) begin
                n_cmp++;
                if (key_valid !== 1'b1 || key_code !== 4'd4 || press_pulse !== 9'h048) begin
                    n_err++; $display("FAIL simul_event: kv=%b code=%0d pulse=%h want 1/4/048", key_valid, key_code, press_pulse);
                end
            end
        end
        n_cmp++;
        if (kvs != 1) begin
            n_err++; $display("FAIL simul_count: %0d events want 1", kvs);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        int kvs = 0;
        btn_raw = 9'h002;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({btn_level, press_pulse, key_valid, key_code, busy} !== 24'h0) begin
            n_err++; $display("FAIL midreset_zero: got %h want 0", {btn_level, press_pulse, key_valid, key_code, busy});
        end
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            kvs += int'(key_valid);
            n_cmp++;
            if (btn_level[1] !== (c >= 5) || key_valid !== (c == 6) || (c == 6 && key_code !== 4'd2) ||
                {btn_level, press_pulse, key_valid, key_code, busy} !== {m_lvl, m_pulse, m_kv, m_kc, m_locked}) begin
                n_err++;
                $display("FAIL midreset c%0d: lvl=%h kv=%b code=%0d", c, btn_level, key_valid, key_code);
            end
        end
        n_cmp++;
        if (kvs != 1) begin
            n_err++; $display("FAIL midreset_count: %0d events want 1", kvs);
        end
        settle();
    endtask

    task automatic test_random();
        logic prev_kv = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) begin
                btn_raw = ($urandom_range(2) == 0) ? 9'h000 : 9'($urandom) & 9'($urandom);
            end
            reset = ($urandom_range(299) != 0);
            tick();
            n_cmp++;
            if ({btn_level, press_pulse, key_valid, key_code, busy} !== {m_lvl, m_pulse, m_kv, m_kc, m_locked}) begin
                n_err++;
                $display("FAIL random_model c%0d: got %h want %h", c,
                         {btn_level, press_pulse, key_valid, key_code, busy}, {m_lvl, m_pulse, m_kv, m_kc, m_locked});
            end
            n_cmp++;
            if (prev_kv && key_valid) begin
                n_err++; $display("FAIL random_back_to_back c%0d: kv=%b after kv=%b", c, key_valid, prev_kv);
            end
            prev_kv = key_valid;
        end
        reset = 1'b1;
        settle();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_hold_other();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
